// File: rtl/reg_bank_snap.sv
// Byte-wide host register bank: coherent snapshot of N_IN status words, control bytes, sticky status.
// Optional lock timeout is enabled by defining REG_BANK_SNAP_TIMEOUT_EN.
module reg_bank_snap #(
    parameter int                 N_IN    = 6,
    parameter int                 N_CTL   = 4,
    parameter int                 ADDR_W  = 5,
    parameter logic [N_CTL*8-1:0] CTL_RST = '0,
    parameter int                 LOCK_TO = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    address,
    input  logic [7:0]           wdBus,
    output logic [7:0]           rdBus,
    input  logic [N_IN*32-1:0]   in_words,
    output logic [N_CTL*8-1:0]   control,
    output logic [N_CTL-1:0]     ctl_stb,
    output logic                 locked
);

    localparam int SNAP_B = 4 * N_IN;
    localparam int STAT_A = SNAP_B;
    localparam int LK_W   = ADDR_W - 2;

    if ((1 << ADDR_W) < SNAP_B + 1 + N_CTL) begin : g_bad_addr_w
        $error("reg_bank_snap: ADDR_W too small for the address map");
    end
    if (LOCK_TO < 1 || LOCK_TO > 65535) begin : g_bad_lock_to
        $error("reg_bank_snap: LOCK_TO out of range");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state;
    logic [LK_W-1:0]     lk;
    logic [N_IN*32-1:0]  snap;
    logic                wr_err;
    logic                to_err;
    logic                rd_acc;
    logic                wr_acc;
    logic                word0_rd;
    logic                rel_rd;
    logic                stat_rd;
    logic                ctl_wr_hit;
    logic                to_hit;
    logic [N_CTL-1:0]    ctl_hit;
    logic [7:0]          rd_data;

    assign rd_acc     = en & ~we;
    assign wr_acc     = en & we;
    assign word0_rd   = rd_acc && (int'(address) < SNAP_B) && (address[1:0] == 2'b00);
    assign rel_rd     = rd_acc && (state == LOCKED) && (address == {lk, 2'b11});
    assign stat_rd    = rd_acc && (address == ADDR_W'(STAT_A));
    assign ctl_wr_hit = |ctl_hit;
    assign locked     = (state == LOCKED);

    always_comb begin
        ctl_hit = '0;
        for (int c = 0; c < N_CTL; c++) begin
            ctl_hit[c] = (address == ADDR_W'(STAT_A + 1 + c));
        end
    end

    // Unmapped addresses fall through to the 0x00 default.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < SNAP_B; i++) begin
            if (address == ADDR_W'(i)) rd_data = snap[8*i +: 8];
        end
        if (address == ADDR_W'(STAT_A)) rd_data = {5'b0, to_err, wr_err, locked};
        for (int c = 0; c < N_CTL; c++) begin
            if (ctl_hit[c]) rd_data = control[8*c +: 8];
        end
    end

`ifdef REG_BANK_SNAP_TIMEOUT_EN
    logic [15:0] timer;

    // Timeout fires on the edge the count would reach LOCK_TO; host accesses win.
    assign to_hit = (state == LOCKED) && !word0_rd && !rel_rd && (timer == 16'(LOCK_TO - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (word0_rd || state == IDLE || rel_rd || to_hit) begin
            timer <= '0;
        end else begin
            timer <= timer + 16'd1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            lk    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (word0_rd) begin
                        state <= LOCKED;
                        lk    <= address[ADDR_W-1:2];
                    end
                end
                LOCKED: begin
                    if (word0_rd) begin
                        lk <= address[ADDR_W-1:2];
                    end else if (rel_rd || to_hit) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The lock-entry edge itself must not overwrite the byte-0 value being returned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap <= '0;
        end else if (state == IDLE && !word0_rd) begin
            snap <= in_words;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdBus   <= 8'h00;
            wr_err  <= 1'b0;
            to_err  <= 1'b0;
            control <= CTL_RST;
            ctl_stb <= '0;
        end else begin
            if (rd_acc) rdBus <= rd_data;

            if (wr_acc && !ctl_wr_hit) wr_err <= 1'b1;
            else if (stat_rd)          wr_err <= 1'b0;

            if (to_hit)       to_err <= 1'b1;
            else if (stat_rd) to_err <= 1'b0;

            for (int c = 0; c < N_CTL; c++) begin
                if (wr_acc && ctl_hit[c]) control[8*c +: 8] <= wdBus;
            end
            ctl_stb <= wr_acc ? ctl_hit : '0;
        end
    end

endmodule

// File: doc/reg_bank_snap.md
# reg_bank_snap

Parametrised successor to the byte-wide host register bank. It captures N_IN 32-bit status words into a byte-addressed snapshot and serves them over the 8-bit host bus. A lock state machine keeps multi-byte word reads coherent. It also provides N_CTL writable control bytes with per-byte write strobes, and a status byte with sticky error flags.

## Interface
- N_IN, 6, number of 32-bit input words captured
- N_CTL, 4, number of host-writable control bytes
- ADDR_W, 5, host address width; must satisfy 2^ADDR_W ≥ 4*N_IN+1+N_CTL
- CTL_RST, {N_CTL*8{1'b0}}, reset value of the control bytes
- LOCK_TO, 255, lock timeout in clk cycles; 1..65535; used only when REG_BANK_SNAP_TIMEOUT_EN is defined
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  host access strobe; a read or write happens on any edge where en=1
- we  in  1  write when 1, read when 0; qualified by en
- address  in  ADDR_W  host byte address
- wdBus  in  8  write data
- rdBus  out  8  registered read data
- in_words  in  N_IN*32  status words; word k is in_words[32k+31:32k]
- control  out  N_CTL*8  control bytes; byte c is control[8c+7:8c]
- ctl_stb  out  N_CTL  one-cycle pulse per control byte written
- locked  out  1  snapshot frozen (LOCKED state)

## Operation
- Address map:
  - 4k+b (k<N_IN, b=0..3): snapshot byte b of word k, little-endian.
  - S=4*N_IN: status byte.
  - S+1+c (c<N_CTL): control byte c.
  - All higher addresses: unmapped.
- Snapshot: in IDLE, every edge loads all of in_words. In LOCKED, the snapshot holds. Capture does not depend on en.
- Lock FSM has two states, IDLE and LOCKED. It holds a word-index register lk.
  - IDLE → LOCKED on a read of address 4k. That same edge does not update the snapshot. lk←k.
  - LOCKED, read of 4j (any j): stay LOCKED, lk←j, timer restarts.
  - LOCKED, read of 4*lk+3: → IDLE. Capture resumes on the next edge.
  - Reads of other addresses and all writes do not change the FSM.
- Reads: rdBus ← mapped byte on the access edge. Unmapped addresses return 0x00. If en=0, rdBus holds its value.
- Status byte:
  - bit0 = locked.
  - bit1 = wr_err (sticky): set by a write to any address other than a control byte.
  - bit2 = to_err (sticky): set by lock timeout.
  - bits7:3 = 0.
  - A read of S returns the current bits, then clears bit1 and bit2. If a set and a clear occur on the same edge, the set wins.
- Control writes: a write to S+1+c loads byte c on the access edge, and ctl_stb[c]=1 for exactly the following cycle. Control bytes are never modified by the hardware.
- Writes to snapshot, status or unmapped addresses do not change data; they set wr_err.

## Timing
- Read latency: 1 edge. The value is visible on rdBus after the edge where en=1, we=0.
- A control byte is visible on control after its write edge. ctl_stb is high in the same cycle the new value first appears.
- Back-to-back accesses are allowed on every cycle; there is no wait state.
- Reading byte 0 always returns the value captured on that edge's predecessor. Bytes 1..3 of the same word, read while LOCKED, are coherent with it.
- Reset (asynchronous, mid-operation included) puts:
  - rdBus=0x00, snapshot=0, FSM=IDLE, lk=0, locked=0
  - wr_err=to_err=0, control=CTL_RST, ctl_stb=0, timer=0

## Configuration
- REG_BANK_SNAP_TIMEOUT_EN defined:
  - A 16-bit timer clears on lock entry and on relock, and increments each cycle while LOCKED.
  - When it reaches LOCK_TO, the FSM → IDLE and to_err is set.
  - If a byte-3 release happens on the same edge, the release wins and to_err is not set.
- Not defined: no timer; LOCKED persists until the byte-3 read; status bit2 always reads 0.

## Test plan
- Reset with control defaults; CTL_RST=0xA5A5A5A5. Deassert reset → control=0xA5A5A5A5, rdBus=0x00, locked=0, status read returns 0x00.
- Coherent read: word1=0x11223344, read address 4. Then change word1 to 0xFFFFFFFF and read addresses 5, 6, 7 → rdBus 0x44, 0x33, 0x22, 0x11. locked drops after the address-7 read. A re-read of 4 then returns 0xFF.
- Control write: write 0x5C to address S+3 (byte 2) → control[23:16]=0x5C and ctl_stb=3'b100 for one cycle. Then write 0x01 to address 2 → status read returns 0x02, and the second status read returns 0x00.
- Relock: read 0, then read 8 while LOCKED → lk=2, still locked. Reading 3 does not release; reading 11 releases.
- Timeout (macro on, LOCK_TO=10): read 0, then idle → locked falls after 10 cycles and a status read returns 0x04. With the macro off, locked stays 1 for 1000 cycles.
- Unmapped read of address 31 (N_IN=6, N_CTL=4) → 0x00. Assert reset while LOCKED → locked=0 immediately, without waiting for a clock edge.
